// File: rtl/alu_control_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_mdu
// Desc     : ALU control-code decoder with an optional iterative multiply/divide
//            unit. Define ALU_CONTROL_MDU_EN to build the multiply/divide path.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_mdu #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_md,
    output logic [XLEN-1:0]   md_result,
    output logic              illegal
);

    localparam logic [CTRL_W-1:0] c_and  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] c_or   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] c_add  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] c_sll  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] c_slt  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] c_sltu = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] c_sub  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] c_xor  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] c_srl  = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] c_sra  = CTRL_W'(4'b1010);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_run;
    logic              w_xfer;
    logic              w_calc_last;
    logic [CTRL_W-1:0] w_base_ctrl;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_md;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;

    // r_run holds in_ready low until the first clock edge after reset release
    assign in_ready  = r_run & (r_state == S_IDLE);
    assign w_xfer    = in_valid & in_ready;
    assign out_valid = (r_state == S_DONE);
    assign ctrl      = r_ctrl;
    assign illegal   = r_illegal;

    always_comb begin
        w_base_ctrl = c_add;
        case (funct3)
            3'b000:  w_base_ctrl = c_add;
            3'b001:  w_base_ctrl = c_sll;
            3'b010:  w_base_ctrl = c_slt;
            3'b011:  w_base_ctrl = c_sltu;
            3'b100:  w_base_ctrl = c_xor;
            3'b101:  w_base_ctrl = c_srl;
            3'b110:  w_base_ctrl = c_or;
            default: w_base_ctrl = c_and;
        endcase
    end

    always_comb begin
        w_dec_ctrl    = c_add;
        w_dec_illegal = 1'b0;
        w_dec_md      = 1'b0;
        case (aluop)
            2'b00: w_dec_ctrl = c_add;
            2'b01: w_dec_ctrl = c_sub;
            2'b10: begin
                case (funct7)
                    7'b0000000: w_dec_ctrl = w_base_ctrl;
                    7'b0100000: begin
                        if (funct3 == 3'b000)      w_dec_ctrl    = c_sub;
                        else if (funct3 == 3'b101) w_dec_ctrl    = c_sra;
                        else                       w_dec_illegal = 1'b1;
                    end
`ifdef ALU_CONTROL_MDU_EN
                    7'b0000001: w_dec_md = 1'b1;
`endif
                    default:    w_dec_illegal = 1'b1;
                endcase
            end
            default: begin
                w_dec_ctrl = w_base_ctrl;
                if (funct3 == 3'b101 && funct7 == 7'b0100000)
                    w_dec_ctrl = c_sra;
                else if ((funct3 == 3'b001 || funct3 == 3'b101) &&
                         funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    w_dec_illegal = 1'b1;
            end
        endcase
        if (w_dec_illegal || w_dec_md)
            w_dec_ctrl = c_and;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if (w_xfer) begin
                r_ctrl    <= w_dec_ctrl;
                r_illegal <= w_dec_illegal;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_next = w_dec_md ? S_CALC : S_DONE;
            S_CALC:  if (w_calc_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

`ifdef ALU_CONTROL_MDU_EN
    localparam int CNT_W = $clog2(XLEN + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_div0;
    logic              r_is_md;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_md_result;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    logic              w_sa;
    logic              w_sb;
    logic              w_neg_in;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_fix;

    assign is_md       = r_is_md;
    assign md_result   = r_md_result;
    assign w_calc_last = (r_cnt == CNT_W'(1));

    // Signed variants run on magnitudes; the sign is restored on the last step
    assign w_sa     = op_a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                      funct3 == 3'b100 || funct3 == 3'b110);
    assign w_sb     = op_b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 ||
                                      funct3 == 3'b110);
    assign w_neg_in = (funct3 == 3'b001 || funct3 == 3'b100) ? (w_sa ^ w_sb) :
                      (funct3 == 3'b010 || funct3 == 3'b110) ? w_sa : 1'b0;
    assign w_mag_a  = w_sa ? -op_a : op_a;
    assign w_mag_b  = w_sb ? -op_b : op_b;

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        ({(XLEN+1){r_acc[0]}} & {1'b0, r_mcand});
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Partial remainder stays below the divisor, so the difference fits XLEN bits
    assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge       = (w_shift >= {1'b0, r_mcand});
    assign w_diff     = w_shift[XLEN-1:0] - r_mcand;
    assign w_div_next = {(w_ge ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
    assign w_q        = w_acc_next[XLEN-1:0];
    assign w_r        = w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_fix = '0;
        case (r_op)
            3'b000:                 w_fix = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix = r_div0 ? '1 : (r_neg ? -w_q : w_q);
            default:                w_fix = r_div0 ? r_op_a : (r_neg ? -w_r : w_r);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_div0      <= 1'b0;
            r_is_md     <= 1'b0;
            r_op_a      <= '0;
            r_mcand     <= '0;
            r_md_result <= '0;
            r_acc       <= '0;
        end else if (w_xfer) begin
            r_is_md     <= w_dec_md;
            r_md_result <= '0;
            if (w_dec_md) begin
                r_cnt   <= CNT_W'(XLEN);
                r_op    <= funct3;
                r_neg   <= w_neg_in;
                r_div0  <= funct3[2] & (op_b == '0);
                r_op_a  <= op_a;
                r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                r_mcand <= funct3[2] ? w_mag_b : w_mag_a;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_calc_last)
                r_md_result <= w_fix;
        end
    end
`else
    logic unused_ops;

    assign unused_ops  = ^{op_a, op_b};
    assign is_md       = 1'b0;
    assign md_result   = '0;
    assign w_calc_last = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mdu.sv
`default_nettype none
// Testbench for alu_control_mdu: directed vectors feed a scoreboard queue that an
// independent output monitor drains and compares.
module tb_alu_control_mdu;
    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      aluop = '0;
    logic [6:0]      funct7 = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [3:0]      ctrl;
    logic            is_md;
    logic [XLEN-1:0] md_result;
    logic            illegal;

    typedef struct {
        string           name;
        logic [3:0]      ctrl;
        logic            is_md;
        logic [XLEN-1:0] res;
        logic            ill;
        int              lat;
        int              xfer;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        mon_busy = 1'b0;
    logic [37:0] held;

    alu_control_mdu #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl), .is_md(is_md),
        .md_result(md_result), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    // Monitor: pops one expectation per new result, then checks it stays put while held
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (out_valid) begin
            if (!mon_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected no result at cycle %0d", cyc);
                end else begin
                    cur = sb_q.pop_front();
                    check({cur.name, "_ctrl"}, 64'(ctrl), 64'(cur.ctrl));
                    check({cur.name, "_is_md"}, 64'(is_md), 64'(cur.is_md));
                    check({cur.name, "_md_result"}, 64'(md_result), 64'(cur.res));
                    check({cur.name, "_illegal"}, 64'(illegal), 64'(cur.ill));
                    check({cur.name, "_latency"}, 64'(cyc - cur.xfer + 1), 64'(cur.lat));
                end
                held = {ctrl, is_md, illegal, md_result};
            end else begin
                check("hold_stable", 64'({ctrl, is_md, illegal, md_result}), 64'(held));
            end
            mon_busy = !out_ready;
        end else begin
            mon_busy = 1'b0;
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [3:0] ectrl, input logic emd, input logic [XLEN-1:0] eres,
                         input logic eill, input int elat, input bit track);
        exp_t e;
        int   n;
        n = 0;
        aluop = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: got in_ready=0 for 200 cycles expected 1", name);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.name = name; e.ctrl = ectrl; e.is_md = emd; e.res = eres; e.ill = eill;
        e.lat = elat; e.xfer = cyc;
        if (track) sb_q.push_back(e);
    endtask

    task automatic base(input string name, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [3:0] ectrl);
        issue(name, op, f7, f3, 32'h1234_5678, 32'h9abc_def0, ectrl, 1'b0, '0, 1'b0, 1, 1'b1);
    endtask

    task automatic ill(input string name, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        issue(name, op, f7, f3, 32'h0000_0005, 32'h0000_0003, 4'b0000, 1'b0, '0, 1'b1, 1, 1'b1);
    endtask

    task automatic md(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
`ifdef ALU_CONTROL_MDU_EN
        issue(name, 2'b10, 7'b0000001, f3, a, b, 4'b0000, 1'b1, res, 1'b0, MD_LAT, 1'b1);
`else
        issue(name, 2'b10, 7'b0000001, f3, a, b, 4'b0000, 1'b0, '0, 1'b1, 1, 1'b1);
        if (res === 'x) $display("unreachable");
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ctrl", 64'(ctrl), 64'd0);
        check("reset_is_md", 64'(is_md), 64'd0);
        check("reset_md_result", 64'(md_result), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 64'(in_ready), 64'd1);

        base("ld_add", 2'b00, 7'b0100000, 3'b111, 4'b0010);
        base("br_sub", 2'b01, 7'b0000001, 3'b101, 4'b0110);
        base("r_add",  2'b10, 7'b0000000, 3'b000, 4'b0010);
        base("r_sll",  2'b10, 7'b0000000, 3'b001, 4'b0011);
        base("r_slt",  2'b10, 7'b0000000, 3'b010, 4'b0100);
        base("r_sltu", 2'b10, 7'b0000000, 3'b011, 4'b0101);
        base("r_xor",  2'b10, 7'b0000000, 3'b100, 4'b0111);
        base("r_srl",  2'b10, 7'b0000000, 3'b101, 4'b1000);
        base("r_or",   2'b10, 7'b0000000, 3'b110, 4'b0001);
        base("r_and",  2'b10, 7'b0000000, 3'b111, 4'b0000);
        base("r_sub",  2'b10, 7'b0100000, 3'b000, 4'b0110);
        base("r_sra",  2'b10, 7'b0100000, 3'b101, 4'b1010);
        ill("r_alt_slt_ill", 2'b10, 7'b0100000, 3'b010);
        ill("r_f7_ill",      2'b10, 7'b1111111, 3'b000);
        base("i_add_any_f7", 2'b11, 7'b1010101, 3'b000, 4'b0010);
        base("i_or_any_f7",  2'b11, 7'b1111111, 3'b110, 4'b0001);
        base("i_sra",        2'b11, 7'b0100000, 3'b101, 4'b1010);
        base("i_srl",        2'b11, 7'b0000000, 3'b101, 4'b1000);
        base("i_sll_alt_f7", 2'b11, 7'b0100000, 3'b001, 4'b0011);
        ill("i_sll_ill",     2'b11, 7'b0000001, 3'b001);
        ill("i_srx_ill",     2'b11, 7'b0010000, 3'b101);

        md("mul",       3'b000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9);
        md("mulh_neg",  3'b001, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF);
        md("mulh_pos",  3'b001, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001);
        md("mulhsu",    3'b010, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001);
        md("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        md("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        md("div_neg",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        md("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        md("div_negb",  3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        md("rem_negb",  3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001);
        md("divu_z",    3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
        md("remu_z",    3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
        md("div_z",     3'b100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF);
        md("rem_z",     3'b110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);
        md("divu",      3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
        md("remu",      3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
        md("divu_big",  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
        drain();

        // Consumer stalls with a competing request pending
        out_ready = 1'b0;
        base("hold_sub", 2'b10, 7'b0100000, 3'b000, 4'b0110);
        aluop = 2'b10; funct7 = 7'b0000000; funct3 = 3'b111; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        drain();

`ifdef ALU_CONTROL_MDU_EN
        issue("div_abort", 2'b10, 7'b0000001, 3'b100, 32'd1000, 32'd7,
              4'b0000, 1'b1, 32'd142, 1'b0, MD_LAT, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("abort_pre_valid", 64'(out_valid), 64'd0);
`else
        out_ready = 1'b0;
        ill("md_disabled_ill", 2'b10, 7'b0000001, 3'b100);
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_valid", 64'(out_valid), 64'd1);
`endif
        rst_n = 1'b0;
        #1;
        check("abort_rst_in_ready", 64'(in_ready), 64'd0);
        check("abort_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after_release", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_valid", 64'(out_valid), 64'd0);
        base("post_abort_xor", 2'b10, 7'b0000000, 3'b100, 4'b0111);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_control_mdu.md
ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width, legal range 8..64.
REQ-002 Parameter CTRL_W, default 4, ALU control code width, fixed at 4 for this generation.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-006 aluop  input  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
REQ-007 funct7  input  7  instruction funct7 field; funct3  input  3  instruction funct3 field.
REQ-008 op_a, op_b  input  XLEN each  multiply/divide operands.
REQ-009 out_valid  output  1  result held; out_ready  input  1  consumer accepts.
REQ-010 ctrl  output  CTRL_W  ALU control code; is_md  output  1  result is from multiply/divide.
REQ-011 md_result  output  XLEN  multiply/divide result; illegal  output  1  undecodable request.

Function
REQ-012 Handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in state IDLE.
REQ-013 States IDLE, CALC, DONE: IDLE->DONE on base/illegal transfer; IDLE->CALC on multiply/divide transfer; CALC->DONE after XLEN iterations; DONE->IDLE on out_ready=1.
REQ-014 out_valid=1 exactly in DONE; ctrl, is_md, md_result, illegal stable throughout DONE.
REQ-015 Latency: base op out_valid 1 cycle after transfer; multiply/divide out_valid XLEN+1 cycles after transfer, independent of operand values.
REQ-016 Codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SLT 0100, SLTU 0101, SUB 0110, XOR 0111, SRL 1000, SRA 1010.
REQ-017 aluop 00 -> ADD; aluop 01 -> SUB; funct fields ignored.
REQ-018 aluop 10, funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-019 aluop 10, funct7 0100000: funct3 000 SUB, 101 SRA, all other funct3 illegal.
REQ-020 aluop 11: funct3 decoded as REQ-018 ignoring funct7, except funct3 101 with funct7 0100000 -> SRA, funct3 001/101 with funct7 not 0000000/0100000 illegal.
REQ-021 aluop 10, funct7 0000001: multiply/divide op by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; is_md=1, ctrl=0000.
REQ-022 Any other aluop 10 funct7 value illegal: illegal=1, ctrl=0000, is_md=0, md_result=0.
REQ-023 Base ops: is_md=0, md_result=0.
REQ-024 MUL low XLEN bits of product; MULH/MULHSU/MULHU high XLEN bits, operands signed/signed, signed/unsigned, unsigned/unsigned.
REQ-025 Multiply iterative shift-add, one operand bit per CALC cycle, 2*XLEN accumulator.
REQ-026 Divide iterative restoring, one quotient bit per CALC cycle, signed ops on magnitudes with sign fix-up on entry to DONE; remainder sign follows dividend.
REQ-027 Divide by zero: quotient all ones, remainder = op_a.
REQ-028 Signed overflow (op_a = most negative, op_b = all ones): DIV = op_a, REM = 0.
REQ-029 in_valid in CALC/DONE ignored; operands sampled only on transfer.
REQ-030 Iteration counter width clog2(XLEN+1), reloaded to XLEN on every multiply/divide transfer.

Reset
REQ-031 rst_n=0 forces IDLE; out_valid, ctrl, is_md, md_result, illegal, counter, accumulators all 0.
REQ-032 in_ready=0 while rst_n=0; in_ready=1 from the first rising edge after release.
REQ-033 Reset during CALC or DONE aborts the operation; no out_valid for it after release.

Configuration
REQ-034 Macro ALU_CONTROL_MDU_EN defined: multiply/divide datapath, CALC state and REQ-021..REQ-028 present.
REQ-035 Macro ALU_CONTROL_MDU_EN undefined: no multiply/divide hardware; funct7 0000001 illegal per REQ-022; md_result tied 0, is_md tied 0, CALC unreachable.

Verification
REQ-036 aluop=10, funct7=0100000, funct3=000 -> 1 cycle later out_valid=1, ctrl=0110, illegal=0.
REQ-037 XLEN=32, MUL op_a=0xFFFFFFFF, op_b=7 -> out_valid at cycle 33, md_result=0xFFFFFFF9, is_md=1.
REQ-038 DIV op_a=0x80000000, op_b=0xFFFFFFFF -> md_result=0x80000000; REM same operands -> 0x00000000.
REQ-039 DIVU op_a=5, op_b=0 -> 0xFFFFFFFF; REMU -> 0x00000005; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-040 out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs held, in_ready=0, no new transfer; out_ready=1 -> IDLE next cycle.
REQ-041 rst_n=0 at CALC cycle 10 of DIV -> no out_valid, in_ready=1 first edge after release; macro undefined, funct7=0000001 -> illegal=1 after 1 cycle.
